// File: rtl/uart_rx_ovs_pkg.sv
// Shared types and helpers for the oversampling UART receiver (uart_rx_ovs).
// FSM state codes, parity modes and the ticks-per-bit helper.
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_WAIT_IDLE = 3'd0;
    localparam uart_state_t ST_IDLE      = 3'd1;
    localparam uart_state_t ST_START     = 3'd2;
    localparam uart_state_t ST_DATA      = 3'd3;
    localparam uart_state_t ST_PARITY    = 3'd4;
    localparam uart_state_t ST_STOP      = 3'd5;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    function automatic int ticks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_ovs_if.sv
// Output handshake of uart_rx_ovs: one received word plus its error flags.
interface uart_rx_ovs_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_frame_err;
    logic             out_parity_err;

    modport master (
        output out_data,
        output out_valid,
        output out_frame_err,
        output out_parity_err,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_frame_err,
        input  out_parity_err,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_ovs_sampler.sv
// Line front end for uart_rx_ovs: two-flop synchroniser, per-bit counter and
// 3-sample majority vote around mid-bit, with decide / bit_end strobes.
module uart_bit_sampler #(
    parameter int TPB = 48
) (
    input  logic clock,
    input  logic reset,
    input  logic rx,
    input  logic run,
    output logic s,
    output logic s_live,
    output logic bit_value,
    output logic decide,
    output logic bit_end
);
    localparam int HALF = TPB / 2;
    localparam int CW   = $clog2(TPB);

    localparam logic [CW-1:0] C_CAP_A = CW'(HALF - 2);
    localparam logic [CW-1:0] C_CAP_B = CW'(HALF - 1);
    localparam logic [CW-1:0] C_MID   = CW'(HALF);
    localparam logic [CW-1:0] C_END   = CW'(TPB - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [1:0]    warm_q, warm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cap_a_q, cap_a_d;
    logic          cap_b_q, cap_b_d;

    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        // Synchroniser resets to 1; s is not trusted until rx has reached it.
        warm_d  = {warm_q[0], 1'b1};
        cnt_d   = '0;
        if (run) cnt_d = (cnt_q == C_END) ? '0 : cnt_q + CW'(1);
        cap_a_d = cap_a_q;
        cap_b_d = cap_b_q;
        if (run && cnt_q == C_CAP_A) cap_a_d = sync2_q;
        if (run && cnt_q == C_CAP_B) cap_b_d = sync2_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            warm_q  <= '0;
            cnt_q   <= '0;
            cap_a_q <= 1'b1;
            cap_b_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            warm_q  <= warm_d;
            cnt_q   <= cnt_d;
            cap_a_q <= cap_a_d;
            cap_b_q <= cap_b_d;
        end
    end

    assign s         = sync2_q;
    assign s_live    = warm_q[1];
    assign bit_value = (cap_a_q & cap_b_q) | (cap_a_q & sync2_q) | (cap_b_q & sync2_q);
    assign decide    = run && (cnt_q == C_MID);
    assign bit_end   = run && (cnt_q == C_END);

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with framing/overrun reporting and a one-word
// holding register. Optional parity bit enabled by macro UART_RX_PARITY_EN.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CLOCK_FREQ = 460800,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_ODD = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rx,
    uart_rx_ovs_if.master out_if,
    output logic          overrun,
    output logic          busy
);
    localparam int TPB = ticks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam logic [4:0] LAST_IDX = 5'(WIDTH - 1);

    if (TPB < 4) begin : g_bad_tpb
        $error("uart_rx_ovs: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("uart_rx_ovs: WIDTH must be 1..16");
    end
    if (PARITY_ODD != PAR_EVEN && PARITY_ODD != PAR_ODD) begin : g_bad_par
        $error("uart_rx_ovs: PARITY_ODD must be 0 or 1");
    end

    logic s, s_live, bit_value, decide, bit_end, run;

    uart_state_t      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [4:0]       idx_q, idx_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;
    logic             done, load;
`ifdef UART_RX_PARITY_EN
    logic             par_err_q, par_err_d;
    logic             perr_q, perr_d;
`endif

    assign run = (state_q == ST_START) || (state_q == ST_DATA) ||
                 (state_q == ST_PARITY) || (state_q == ST_STOP);

    uart_bit_sampler #(.TPB(TPB)) u_sampler (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .run       (run),
        .s         (s),
        .s_live    (s_live),
        .bit_value (bit_value),
        .decide    (decide),
        .bit_end   (bit_end)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            ST_WAIT_IDLE: if (s && s_live) state_d = ST_IDLE;
            ST_IDLE: begin
                if (!s) begin
                    state_d = ST_START;
                    idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                    par_err_d = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (decide && bit_value) state_d = ST_IDLE;
                else if (bit_end)        state_d = ST_DATA;
            end
            ST_DATA: begin
                if (decide) begin
                    for (int i = 0; i < WIDTH - 1; i++) shift_d[i] = shift_q[i+1];
                    shift_d[WIDTH-1] = bit_value;
                end
                if (bit_end) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (decide) par_err_d = bit_value ^ (^shift_q) ^ 1'(PARITY_ODD);
                if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                // A good stop returns to IDLE at mid-bit to gain resync margin.
                if (decide) begin
                    done    = 1'b1;
                    state_d = bit_value ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    always_comb begin
        load      = done && (!valid_q || out_if.out_ready);
        valid_d   = valid_q;
        data_d    = data_q;
        ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
        perr_d    = perr_q;
`endif
        if (load) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            ferr_d  = !bit_value;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_err_q;
`endif
        end else if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
        end
        overrun_d = done && !load;
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_WAIT_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign out_if.out_data      = data_q;
    assign out_if.out_valid     = valid_q;
    assign out_if.out_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign out_if.out_parity_err = perr_q;
`else
    assign out_if.out_parity_err = 1'b0;
`endif
    assign overrun = overrun_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Self-checking bench for uart_rx_ovs: frame-level reference model plus
// directed literal checks; random data, glitches, stop errors and ready.
module tb_uart_rx_ovs;
    localparam int WIDTH      = 8;
    localparam int CLOCK_FREQ = 460800;
    localparam int BAUD_RATE  = 9600;
    localparam int PARITY_ODD = 0;
    localparam int TPB        = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF       = TPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // Edge of the stop decision, counted from the first edge that sees rx low.
    localparam int LAT = 2 + (WIDTH + 1 + P) * TPB + HALF + 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;
    logic overrun, busy;

    uart_rx_ovs_if #(.WIDTH(WIDTH)) oif ();

    uart_rx_ovs #(
        .WIDTH(WIDTH), .CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .rx      (rx),
        .out_if  (oif),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int               edge_n;
        logic [WIDTH-1:0] data;
        logic             ferr;
        logic             perr;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    logic             m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;
    logic [WIDTH-1:0] m_data = '0;

    int rise_cnt = 0, rise_edge = 0, hi_cnt = 0, ovr_cnt = 0;
    logic [WIDTH-1:0] rise_data = '0;
    logic rise_ferr = 1'b0, rise_perr = 1'b0, prev_valid = 1'b0;
    bit   rnd_on = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Holding-register model driven by the scheduled completion edges.
    always @(posedge clock) begin : model
        ev_t e;
        cyc++;
        if (reset) begin
            m_valid = 1'b0; m_ovr = 1'b0; m_data = '0; m_ferr = 1'b0; m_perr = 1'b0;
            evq.delete();
        end else begin
            m_ovr = 1'b0;
            if (evq.size() > 0 && evq[0].edge_n == cyc) begin
                e = evq.pop_front();
                if (!m_valid || oif.out_ready) begin
                    m_valid = 1'b1; m_data = e.data; m_ferr = e.ferr; m_perr = e.perr;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && oif.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (cyc > 0) begin
            check("out_valid", {31'd0, oif.out_valid}, {31'd0, m_valid});
            check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
            if (m_valid) begin
                check("out_data", 32'(oif.out_data), 32'(m_data));
                check("out_frame_err", {31'd0, oif.out_frame_err}, {31'd0, m_ferr});
                check("out_parity_err", {31'd0, oif.out_parity_err}, {31'd0, m_perr});
            end
            if (oif.out_valid && !prev_valid) begin
                rise_cnt++;
                rise_edge = cyc;
                rise_data = oif.out_data;
                rise_ferr = oif.out_frame_err;
                rise_perr = oif.out_parity_err;
            end
            if (oif.out_valid) hi_cnt++;
            if (overrun) ovr_cnt++;
            prev_valid = oif.out_valid;
        end
    end

    always @(negedge clock) if (rnd_on) oif.out_ready = ($urandom_range(0, 3) != 0);

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    // Drives one frame from a negedge; glitches only hit one of the 3 vote samples.
    task automatic send_frame(input logic [WIDTH-1:0] d, input logic stop_b, input logic pflip,
                              input bit glitch, input int tail_low, input int gap,
                              output int e0);
        logic bits[$];
        logic pe;
        int   goff;
        bits.push_back(1'b0);
        for (int i = 0; i < WIDTH; i++) bits.push_back(d[i]);
        pe = 1'b0;
        if (P == 1) begin
            bits.push_back((^d) ^ 1'(PARITY_ODD) ^ pflip);
            pe = pflip;
        end
        bits.push_back(stop_b);
        e0 = cyc + 1;
        evq.push_back('{edge_n: e0 + LAT, data: d, ferr: ~stop_b, perr: pe});
        foreach (bits[b]) begin
            goff = (glitch && $urandom_range(0, 2) == 0) ? HALF - 1 + int'($urandom_range(0, 2)) : -1;
            for (int j = 0; j < TPB; j++) begin
                rx = bits[b] ^ (j == goff);
                @(negedge clock);
            end
        end
        rx = 1'b0;
        repeat (tail_low) @(negedge clock);
        idle(gap);
    endtask

    initial begin
        int e0, r0;
        oif.out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("reset out_valid", {31'd0, oif.out_valid}, 32'd0);
        check("reset overrun", {31'd0, overrun}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset out_data", 32'(oif.out_data), 32'd0);
        check("reset out_frame_err", {31'd0, oif.out_frame_err}, 32'd0);
        reset = 1'b0;
        idle(10);

        // 8N1 word, ready held high: single-cycle valid at the stop decision.
        hi_cnt = 0;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0, 5, e0);
        check("a5 valid edge", 32'(rise_edge - e0), 32'd459);
        check("a5 valid width", 32'(hi_cnt), 32'd1);
        check("a5 data", 32'(rise_data), 32'h0A5);
        check("a5 frame_err", {31'd0, rise_ferr}, 32'd0);
        check("a5 parity_err", {31'd0, rise_perr}, 32'd0);

        // False start: 10 low cycles are rejected by the start vote.
        r0 = rise_cnt;
        e0 = cyc + 1;
        rx = 1'b0;
        repeat (10) @(negedge clock);
        rx = 1'b1;
        while (cyc < e0 + 12) @(negedge clock);
        check("glitch busy high", {31'd0, busy}, 32'd1);
        while (cyc < e0 + 29) @(negedge clock);
        check("glitch busy low", {31'd0, busy}, 32'd0);
        idle(TPB);
        check("glitch no word", 32'(rise_cnt - r0), 32'd0);

        // Overrun: second word dropped while the first is held.
        oif.out_ready = 1'b0;
        ovr_cnt = 0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0, 3, e0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 0, 5, e0);
        check("ovr pulses", 32'(ovr_cnt), 32'd1);
        check("ovr held valid", {31'd0, oif.out_valid}, 32'd1);
        check("ovr held data", 32'(oif.out_data), 32'h011);
        oif.out_ready = 1'b1;
        @(negedge clock);
        check("ovr drained", {31'd0, oif.out_valid}, 32'd0);
        idle(5);

        // Framing error, line held low, then a clean word.
        r0 = rise_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 2 * TPB, TPB, e0);
        check("ferr word count", 32'(rise_cnt - r0), 32'd1);
        check("ferr data", 32'(rise_data), 32'h03C);
        check("ferr flag", {31'd0, rise_ferr}, 32'd1);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 0, 5, e0);
        check("after ferr data", 32'(rise_data), 32'h05A);
        check("after ferr flag", {31'd0, rise_ferr}, 32'd0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 0, 5, e0);
        check("parity bad flag", {31'd0, rise_perr}, 32'd1);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 0, 5, e0);
        check("parity good flag", {31'd0, rise_perr}, 32'd0);
`endif

        // Reset mid-frame with rx low; nothing until the line returns high.
        rx = 1'b0;
        repeat (3 * TPB) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("midrst out_valid", {31'd0, oif.out_valid}, 32'd0);
        check("midrst out_data", 32'(oif.out_data), 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        r0 = rise_cnt;
        repeat (3 * TPB) @(negedge clock);
        check("midrst no word", 32'(rise_cnt - r0), 32'd0);
        idle(10);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 0, 5, e0);
        check("midrst ff data", 32'(rise_data), 32'h0FF);
        check("midrst ff word count", 32'(rise_cnt - r0), 32'd1);

        // Random traffic: data, vote glitches, stop errors, parity, back-pressure.
        rnd_on = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic [WIDTH-1:0] d;
            logic sb, pf;
            d  = WIDTH'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            pf = ($urandom_range(0, 3) == 0);
            if (sb) send_frame(d, 1'b1, pf, 1'b1, 0, int'($urandom_range(0, HALF)), e0);
            else    send_frame(d, 1'b0, pf, 1'b1, int'($urandom_range(0, TPB)),
                               4 + int'($urandom_range(0, TPB)), e0);
        end
        rnd_on = 1'b0;
        @(negedge clock);
        oif.out_ready = 1'b1;
        idle(20);
        check("all words scheduled", 32'(evq.size()), 32'd0);
        check("final drained", {31'd0, oif.out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ovs.md
# uart_rx_ovs

Parametrised UART receiver, successor to the fixed-format receiver. Adds:
- two-flop input synchroniser;
- 3-sample majority vote per bit, with false-start rejection;
- optional parity;
- framing, parity and overrun reporting;
- a one-word holding register behind a valid/ready handshake.

It sits between the serial pin and the RX buffer.

## Interface
Parameters:
- WIDTH, 8, data bits per frame, 1..16
- CLOCK_FREQ, 460800, clock frequency in Hz
- BAUD_RATE, 9600, bit rate; TPB = CLOCK_FREQ/BAUD_RATE (integer division), must be >= 4
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only with UART_RX_PARITY_EN

Ports:
- clock  in  1  single clock; one clock, all logic on its rising edge
- reset  in  1  reset is synchronous and active-high
- rx  in  1  asynchronous serial line, idle high
- out_data  out  WIDTH  received word, LSB first on the line
- out_valid  out  1  holding register full
- out_ready  in  1  consumer accepts the word
- out_frame_err  out  1  stop bit sampled 0; qualified by out_valid
- out_parity_err  out  1  parity mismatch; qualified by out_valid; constant 0 without the macro
- overrun  out  1  one-cycle pulse: completed word dropped because the holding register was full
- busy  out  1  FSM not in IDLE

## Operation
- Synchroniser: two flops; both reset to 1. FSM reads the second flop only (s).
- HALF = TPB/2. A bit counter runs 0..TPB-1 inside every bit.
- Majority sampling:
  - s is captured at counter HALF-1 and HALF.
  - The bit value is decided on the edge where counter == HALF+1, as the majority of the two captures and the current s.
- FSM states and transitions:
  - WAIT_IDLE: go to IDLE when s == 1.
  - IDLE: when s == 0, go to START with counter = 0.
  - START: if the start majority is 1 (glitch), go to IDLE. Otherwise, at counter TPB-1, go to DATA.
  - DATA: shift one bit per TPB, LSB first. After bit WIDTH-1, go to PARITY if compiled in, else STOP.
  - PARITY: compare the parity bit with the computed parity.
  - STOP: on the stop decision edge, finish the word.
    - Stop bit = 1: go straight to IDLE, without waiting for the bit end, to gain half a bit of resync margin.
    - Stop bit = 0: set frame_err and go to WAIT_IDLE.
- Completing a word:
  - Holding register free, or freed this same cycle (out_valid && out_ready): load out_data and both error flags, and set out_valid.
  - Otherwise: the new word is dropped and overrun pulses; the held word is unchanged.
- Handshake:
  - out_valid stays high and out_data stays stable until out_valid && out_ready.
  - When a word is accepted and none is loading, out_valid clears on the next edge.
- Errored words are still delivered, with their flags set.
- Reset:
  - All outputs go to 0 and the FSM to WAIT_IDLE.
  - A frame in progress is discarded. No start is recognised until the line has been seen high.

## Timing
- Edge 0 is the first edge at which the synchroniser captures rx = 0.
- IDLE→START happens at edge 2.
- The start decision is at edge 2+HALF+1.
- Data bit k is decided at edge 2+(k+1)·TPB+HALF+1.
- The stop bit is decided at edge 2+(WIDTH+1+P)·TPB+HALF+1, where P = 1 with parity, else 0.
- out_valid is visible after that edge.
- Defaults (8N1, TPB = 48): out_valid rises at edge 459.
- The overrun pulse occurs in the same cycle in which out_valid would have loaded.
- The next start may be detected on the edge after the stop decision.

## Configuration
- UART_RX_PARITY_EN defined:
  - A parity bit follows the data bits, and the PARITY state exists.
  - out_parity_err = 1 when the received parity bit differs from the XOR of the data, inverted if PARITY_ODD = 1.
- Undefined:
  - No PARITY state; the frame is start, WIDTH data bits, stop.
  - out_parity_err is tied to 0 and PARITY_ODD is ignored.

## Structure
- Package uart_pkg holds:
  - the FSM state enum;
  - function ticks_per_bit(clock_freq, baud_rate);
  - the parity-mode localparams.
- Sub-module uart_bit_sampler owns the synchroniser, bit counter and majority vote. It outputs s, bit_value and the decide / bit_end strobes. The top level holds the FSM, shift register and holding register.

## Test plan
- 8N1, out_ready = 1, send 0xA5 → single out_valid pulse at edge 459, out_data = 0xA5, both error flags 0.
- rx low for 10 cycles, then high → no out_valid, busy returns to 0 before edge 30.
- out_ready = 0, send 0x11 then 0x22 → out_valid held with 0x11, one overrun pulse at the 0x22 stop decision. Raising out_ready then delivers 0x11 only.
- Send 0x3C with the stop bit low, then hold rx low for 2 bit times → out_data = 0x3C with out_frame_err = 1. No new word until rx goes high, then a fresh 0x5A is received correctly.
- Macro on, PARITY_ODD = 0: 0x07 with parity bit 0 → out_parity_err = 1. 0x07 with parity bit 1 → out_parity_err = 0.
- Assert reset mid-frame while rx = 0 → all outputs 0; no word appears until rx goes high and a new frame (0xFF) is sent and received correctly.
